// File: rtl/multi_timer_if.sv
// I/O bus between a bus master and the multi_timer register bank.
// RBUS is the shared tri-state read bus; the slave supplies its data and drive enable.
interface multi_timer_if #(
  parameter int ABITS = 32,
  parameter int DBITS = 32
);
  logic [ABITS-1:0] ABUS;
  logic             RE;
  logic             WE;
  logic [DBITS-1:0] WBUS;
  logic [DBITS-1:0] rd_data;
  logic             rd_oe;
  logic             INTR;
  wire  [DBITS-1:0] RBUS;

  // Read bus is released whenever the slave is not selected for a read
  assign RBUS = rd_oe ? rd_data : {DBITS{1'bz}};

  modport slave  (input ABUS, RE, WE, WBUS, output rd_data, rd_oe, INTR);
  modport master (output ABUS, RE, WE, WBUS, input RBUS, INTR);
endinterface

// File: rtl/multi_timer.sv
// Bank of NCH independent prescaled down-counters with reload, one-shot/auto mode,
// Rdy/Ovr/IE status per channel, a shared STAT register and one ORed interrupt.
module multi_timer #(
  parameter int               ABITS = 32,
  parameter int               DBITS = 32,
  parameter logic [ABITS-1:0] RBASE = 32'hF000_0020,
  parameter int               NCH   = 4,
  parameter int               DIVN  = 25000,
  parameter int               DIVB  = 16
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          LOCK,
  multi_timer_if.slave  bus
);

  localparam logic [DIVB-1:0] DIV_LAST = DIVB'(DIVN - 1);

  function automatic logic [ABITS-1:0] reg_addr(input int ch, input int off);
    reg_addr = RBASE + ABITS'(16 * ch + off);
  endfunction

  logic [NCH-1:0][DBITS-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][DBITS-1:0] res_q, res_d;
  logic [NCH-1:0][DIVB-1:0]  div_q, div_d;
  logic [NCH-1:0]            rdy_q, rdy_d, ovr_q, ovr_d;
  logic [NCH-1:0]            auto_q, auto_d, en_q, en_d, ie_q, ie_d;
  logic                      intr_q, intr_d;

  logic [NCH-1:0]            wr_cnt_s, wr_res_s, wr_ctl_s;
  logic [NCH-1:0]            run_s, tick_s, expire_s;
  logic [DBITS-1:0]          rd_data_s;
  logic                      rd_oe_s;

  // Per-channel next state: count, expire/reload, then bus writes on top
  always_comb begin
    cnt_d    = cnt_q;
    res_d    = res_q;
    div_d    = div_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;
    auto_d   = auto_q;
    en_d     = en_q;
    ie_d     = ie_q;
    wr_cnt_s = '0;
    wr_res_s = '0;
    wr_ctl_s = '0;
    run_s    = '0;
    tick_s   = '0;
    expire_s = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_cnt_s[i] = bus.WE && (bus.ABUS == reg_addr(i, 0));
      wr_res_s[i] = bus.WE && (bus.ABUS == reg_addr(i, 4));
      wr_ctl_s[i] = bus.WE && (bus.ABUS == reg_addr(i, 8));
      run_s[i]    = en_q[i] && (cnt_q[i] != '0) && !wr_cnt_s[i] && !wr_res_s[i];
      tick_s[i]   = run_s[i] && (div_q[i] == DIV_LAST);
      expire_s[i] = tick_s[i] && (cnt_q[i] == DBITS'(1));

      if (tick_s[i]) begin
        div_d[i] = '0;
        cnt_d[i] = cnt_q[i] - DBITS'(1);
      end else if (run_s[i]) begin
        div_d[i] = div_q[i] + DIVB'(1);
      end else begin
        div_d[i] = div_q[i];
      end

      // Status clears from a CTL write come first so a same-cycle expiry wins
      if (wr_ctl_s[i]) begin
        rdy_d[i]  = rdy_q[i] & bus.WBUS[0];
        ovr_d[i]  = ovr_q[i] & bus.WBUS[1];
        auto_d[i] = bus.WBUS[2];
        en_d[i]   = bus.WBUS[3];
        ie_d[i]   = bus.WBUS[4];
      end else begin
        rdy_d[i]  = rdy_q[i];
        ovr_d[i]  = ovr_q[i];
      end

      if (expire_s[i]) begin
        rdy_d[i] = 1'b1;
        ovr_d[i] = ovr_q[i] | rdy_q[i];
        if (auto_q[i] && (res_q[i] != '0)) begin
          cnt_d[i] = res_q[i];
        end else begin
          cnt_d[i] = '0;
        end
      end else begin
        rdy_d[i] = rdy_d[i];
      end

      if (wr_cnt_s[i]) begin
        cnt_d[i] = bus.WBUS;
        div_d[i] = '0;
      end else if (wr_res_s[i]) begin
        res_d[i] = bus.WBUS;
        if (cnt_q[i] == '0) begin
          cnt_d[i] = bus.WBUS;
          div_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        res_d[i] = res_q[i];
      end
    end
    intr_d = |(rdy_d & ie_d);
  end

  // Read mux: combinational so data is valid in the RE cycle
  always_comb begin
    rd_data_s = '0;
    rd_oe_s   = 1'b0;
    if (bus.RE) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ABUS == reg_addr(i, 0)) begin
          rd_oe_s   = 1'b1;
          rd_data_s = cnt_q[i];
        end else if (bus.ABUS == reg_addr(i, 4)) begin
          rd_oe_s   = 1'b1;
          rd_data_s = res_q[i];
        end else if (bus.ABUS == reg_addr(i, 8)) begin
          rd_oe_s   = 1'b1;
          rd_data_s = DBITS'({ie_q[i], en_q[i], auto_q[i], ovr_q[i], rdy_q[i]});
        end else begin
          rd_oe_s   = rd_oe_s;
        end
      end
      if (bus.ABUS == reg_addr(NCH, 0)) begin
        rd_oe_s   = 1'b1;
        rd_data_s = DBITS'(rdy_q & ie_q);
      end else begin
        rd_oe_s   = rd_oe_s;
      end
    end else begin
      rd_oe_s = 1'b0;
    end
  end

  // State registers: everything holds while the PLL is unlocked
  always_ff @(posedge CLK) begin
    if (LOCK) begin
      if (INIT) begin
        cnt_q  <= '0;
        res_q  <= '0;
        div_q  <= '0;
        rdy_q  <= '0;
        ovr_q  <= '0;
        auto_q <= '0;
        en_q   <= '0;
        ie_q   <= '0;
        intr_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        res_q  <= res_d;
        div_q  <= div_d;
        rdy_q  <= rdy_d;
        ovr_q  <= ovr_d;
        auto_q <= auto_d;
        en_q   <= en_d;
        ie_q   <= ie_d;
        intr_q <= intr_d;
      end
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.rd_oe   = rd_oe_s;
  assign bus.INTR    = intr_q;

endmodule
